// File: rtl/rf_pkg.sv
// rf_pkg: shared definitions for the register-file write-port controller.
//   NREG / AW / DW : default register count, address width and data width
//   req_t          : requester identity, also used as the round-robin priority bit
//   state_t        : controller state (init sweep, then normal arbitration)
package rf_pkg;

  localparam int NREG = 8;
  localparam int AW   = 3;
  localparam int DW   = 8;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/rf_wr_ctrl_if.sv
// rf_wr_ctrl_if: bundle between the two writeback requesters, the write-port
// controller and the register file.
//   A_* / B_*       : requester handshakes (valid/addr/data in, ready back)
//   Rf_we/waddr/wdata: registered write port towards the register file
//   Pend            : one-hot of the write currently presented to the file
//   Init_done       : high once the post-reset clear sweep has finished
// Handshake: a requester raises X_valid with X_addr/X_data and holds all three
// stable until it sees X_ready=1; the transfer happens on the rising edge where
// X_valid && X_ready. Ready never depends on addr/data, only on the valids.
// modport master = requester/file side, modport slave = controller.
interface rf_wr_ctrl_if import rf_pkg::*; #(
  parameter int NREG = rf_pkg::NREG,
  parameter int AW   = rf_pkg::AW,
  parameter int DW   = rf_pkg::DW
);

  logic            A_valid;
  logic [AW-1:0]   A_addr;
  logic [DW-1:0]   A_data;
  logic            A_ready;

  logic            B_valid;
  logic [AW-1:0]   B_addr;
  logic [DW-1:0]   B_data;
  logic            B_ready;

  logic            Rf_we;
  logic [AW-1:0]   Rf_waddr;
  logic [DW-1:0]   Rf_wdata;
  logic [NREG-1:0] Pend;
  logic            Init_done;

  modport master (
    output A_valid, A_addr, A_data,
    output B_valid, B_addr, B_data,
    input  A_ready, B_ready,
    input  Rf_we, Rf_waddr, Rf_wdata, Pend, Init_done
  );

  modport slave (
    input  A_valid, A_addr, A_data,
    input  B_valid, B_addr, B_data,
    output A_ready, B_ready,
    output Rf_we, Rf_waddr, Rf_wdata, Pend, Init_done
  );

endinterface

// File: rtl/rf_wr_ctrl_rr_arb2.sv
// rr_arb2: two-request arbiter.
//   Clk, Rst_n : clock, async active-low reset
//   req[1:0]   : requests (bit 0 = A, bit 1 = B)
//   fixed      : 1 = A always wins a contest, 0 = round-robin
//   advance    : grants are live this cycle (priority may rotate)
//   gnt[1:0]   : one-hot grant, combinational from req/fixed/prio
//   prio       : registered requester that wins the next contest
module rr_arb2 import rf_pkg::*; (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [1:0] req,
  input  logic       fixed,
  input  logic       advance,
  output logic [1:0] gnt,
  output req_t       prio
);

  always_comb begin
    gnt = 2'b00;
    if (fixed) begin
      gnt[0] = req[0];
      gnt[1] = req[1] & ~req[0];
    end else if (req == 2'b11) begin
      gnt = (prio == REQ_A) ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

  // Priority always moves to the requester that lost or did not ask,
  // even when the grant was uncontested.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      prio <= REQ_A;
    end else if (advance && (gnt != 2'b00)) begin
      prio <= gnt[0] ? REQ_B : REQ_A;
    end
  end

endmodule

// File: rtl/rf_wr_ctrl.sv
// rf_wr_ctrl: write-port controller for the pipeline register file.
// After reset it sweeps every register with INIT_VAL, then shares the single
// write port between requesters A and B through rr_arb2.
//   Clk, Rst_n : clock, async active-low reset
//   bus        : requester handshakes and register-file write port (slave side)
//   dbg_state  : current controller state
module rf_wr_ctrl import rf_pkg::*; #(
  parameter int            NREG       = rf_pkg::NREG,
  parameter int            AW         = rf_pkg::AW,
  parameter int            DW         = rf_pkg::DW,
  parameter logic [DW-1:0] INIT_VAL   = '0,
  parameter bit            FIXED_PRIO = 1'b0
) (
  input  logic         Clk,
  input  logic         Rst_n,
  rf_wr_ctrl_if.slave  bus,
  output state_t       dbg_state
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(NREG - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q;
  logic          we_q;
  logic [AW-1:0] waddr_q;
  logic [DW-1:0] wdata_q;
  logic          done_q;

  logic          run;
  logic [1:0]    gnt;
  req_t          prio;
  logic          a_ready, b_ready;
  logic          xfer;
  logic [NREG-1:0] pend;

  rr_arb2 u_arb (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .req     ({bus.B_valid, bus.A_valid}),
    .fixed   (FIXED_PRIO),
    .advance (run),
    .gnt     (gnt),
    .prio    (prio)
  );

  // State register
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  // Next state: leave INIT on the edge that loads the last address
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (cnt_q == LAST_ADDR) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // Outputs of the FSM: readies only in RUN, only for the granted requester
  always_comb begin
    run     = (state_q == ST_RUN);
    a_ready = run & gnt[0];
    b_ready = run & gnt[1];
    xfer    = (bus.A_valid & a_ready) | (bus.B_valid & b_ready);
  end

  // Init counter and registered write port
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else if (state_q == ST_INIT) begin
      we_q    <= 1'b1;
      waddr_q <= cnt_q;
      wdata_q <= INIT_VAL;
      cnt_q   <= cnt_q + AW'(1);
      if (cnt_q == LAST_ADDR) done_q <= 1'b1;
    end else begin
      we_q <= xfer;
      if (xfer) begin
        waddr_q <= gnt[0] ? bus.A_addr : bus.B_addr;
        wdata_q <= gnt[0] ? bus.A_data : bus.B_data;
      end
    end
  end

  // In-flight write mask for forwarding/hazard logic
  always_comb begin
    pend = '0;
    if (we_q) pend[waddr_q] = 1'b1;
  end

  assign bus.A_ready   = a_ready;
  assign bus.B_ready   = b_ready;
  assign bus.Rf_we     = we_q;
  assign bus.Rf_waddr  = waddr_q;
  assign bus.Rf_wdata  = wdata_q;
  assign bus.Pend      = pend;
  assign bus.Init_done = done_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_rf_wr_ctrl.sv
// Bench for rf_wr_ctrl: one round-robin instance and one fixed-priority
// instance driven with the same requester stimulus, each checked against a
// transaction-level model of the arbitration rules and of the register file.
module tb_rf_wr_ctrl;
  import rf_pkg::*;

  localparam logic [DW-1:0] INIT_VAL = 8'h00;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  rf_wr_ctrl_if #(.NREG(NREG), .AW(AW), .DW(DW)) bus_rr ();
  rf_wr_ctrl_if #(.NREG(NREG), .AW(AW), .DW(DW)) bus_fx ();
  state_t st_rr, st_fx;

  rf_wr_ctrl #(.NREG(NREG), .AW(AW), .DW(DW), .INIT_VAL(INIT_VAL), .FIXED_PRIO(1'b0))
    dut_rr (.Clk(Clk), .Rst_n(Rst_n), .bus(bus_rr), .dbg_state(st_rr));
  rf_wr_ctrl #(.NREG(NREG), .AW(AW), .DW(DW), .INIT_VAL(INIT_VAL), .FIXED_PRIO(1'b1))
    dut_fx (.Clk(Clk), .Rst_n(Rst_n), .bus(bus_fx), .dbg_state(st_fx));

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;

  // model per instance (0 = round-robin, 1 = fixed)
  bit            m_done [2];
  int            m_cnt  [2];
  bit            m_b_next [2];   // B wins the next contest
  bit            e_we   [2];
  logic [AW-1:0] e_addr [2];
  logic [DW-1:0] e_data [2];
  logic [DW-1:0] ref_rf [2][NREG];
  logic [DW-1:0] sb_rf  [2][NREG];

  // register files fed from the DUT write ports
  always @(posedge Clk) begin
    if (bus_rr.Rf_we) sb_rf[0][bus_rr.Rf_waddr] <= bus_rr.Rf_wdata;
    if (bus_fx.Rf_we) sb_rf[1][bus_fx.Rf_waddr] <= bus_fx.Rf_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_done[k] = 0; m_cnt[k] = 0; m_b_next[k] = 0;
      e_we[k] = 0; e_addr[k] = '0; e_data[k] = '0;
    end
  endtask

  // 0 = nobody, 1 = A, 2 = B
  function automatic int winner(int k, bit av, bit bv);
    if (!m_done[k]) return 0;
    if (av && bv) return (k == 1) ? 1 : (m_b_next[k] ? 2 : 1);
    if (av) return 1;
    if (bv) return 2;
    return 0;
  endfunction

  task automatic chk_outs(input string tag, input int k, input logic we,
                          input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                          input logic [NREG-1:0] pd, input logic dn, input state_t st);
    logic [NREG-1:0] ep;
    ep = e_we[k] ? (NREG'(1) << e_addr[k]) : '0;
    chk({tag, "_we"},    we, e_we[k]);
    chk({tag, "_waddr"}, wa, e_addr[k]);
    chk({tag, "_wdata"}, wd, e_data[k]);
    chk({tag, "_pend"},  pd, ep);
    chk({tag, "_done"},  dn, m_done[k]);
    chk({tag, "_state"}, st, m_done[k] ? ST_RUN : ST_INIT);
  endtask

  task automatic chk_zero(input string tag, input logic we, input logic [AW-1:0] wa,
                          input logic [DW-1:0] wd, input logic [NREG-1:0] pd,
                          input logic dn, input logic ar, input logic br);
    chk({tag, "_rst_we"},    we, 0);
    chk({tag, "_rst_waddr"}, wa, 0);
    chk({tag, "_rst_wdata"}, wd, 0);
    chk({tag, "_rst_pend"},  pd, 0);
    chk({tag, "_rst_done"},  dn, 0);
    chk({tag, "_rst_a_rdy"}, ar, 0);
    chk({tag, "_rst_b_rdy"}, br, 0);
  endtask

  task automatic drive(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input bit bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
    bus_rr.A_valid = av; bus_rr.A_addr = aa; bus_rr.A_data = ad;
    bus_rr.B_valid = bv; bus_rr.B_addr = ba; bus_rr.B_data = bd;
    bus_fx.A_valid = av; bus_fx.A_addr = aa; bus_fx.A_data = ad;
    bus_fx.B_valid = bv; bus_fx.B_addr = ba; bus_fx.B_data = bd;
  endtask

  // Called just after a rising edge. Drives one cycle of requests, checks the
  // readies mid-cycle, then checks the registered outputs after the next edge.
  // rd = {fx_b, fx_a, rr_b, rr_a} as sampled mid-cycle.
  task automatic tick(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input bit bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                      output logic [3:0] rd);
    int w [2];
    drive(av, aa, ad, bv, ba, bd);
    @(negedge Clk);
    for (int k = 0; k < 2; k++) w[k] = winner(k, av, bv);
    rd = {bus_fx.B_ready, bus_fx.A_ready, bus_rr.B_ready, bus_rr.A_ready};
    chk("rr_a_ready", rd[0], w[0] == 1);
    chk("rr_b_ready", rd[1], w[0] == 2);
    chk("fx_a_ready", rd[2], w[1] == 1);
    chk("fx_b_ready", rd[3], w[1] == 2);
    @(posedge Clk);
    for (int k = 0; k < 2; k++) begin
      if (!m_done[k]) begin
        e_we[k] = 1; e_addr[k] = AW'(m_cnt[k]); e_data[k] = INIT_VAL;
        ref_rf[k][m_cnt[k]] = INIT_VAL;
        if (m_cnt[k] == NREG - 1) m_done[k] = 1;
        m_cnt[k]++;
      end else if (w[k] != 0) begin
        e_we[k]   = 1;
        e_addr[k] = (w[k] == 1) ? aa : ba;
        e_data[k] = (w[k] == 1) ? ad : bd;
        ref_rf[k][e_addr[k]] = e_data[k];
        m_b_next[k] = (w[k] == 1);
      end else begin
        e_we[k] = 0;
      end
    end
    #1;
    chk_outs("rr", 0, bus_rr.Rf_we, bus_rr.Rf_waddr, bus_rr.Rf_wdata, bus_rr.Pend, bus_rr.Init_done, st_rr);
    chk_outs("fx", 1, bus_fx.Rf_we, bus_fx.Rf_waddr, bus_fx.Rf_wdata, bus_fx.Pend, bus_fx.Init_done, st_fx);
  endtask

  // ---------------- directed vector table (round-robin instance) ----------------
  typedef struct {
    bit            av;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    bit            bv;
    logic [AW-1:0] ba;
    logic [DW-1:0] bd;
    bit            ea;
    bit            eb;
    bit            ewe;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] edata;
  } vec_t;

  vec_t vt [10];

  task automatic init_sweep(input bit av, input bit bv);
    logic [3:0] rd;
    for (int i = 0; i < NREG; i++) begin
      tick(av, 3'd1, 8'h11, bv, 3'd2, 8'h22, rd);
      chk("init_addr", bus_rr.Rf_waddr, i);
      chk("init_done_edge", bus_rr.Init_done, i == NREG - 1);
    end
  endtask

  initial begin
    logic [3:0]    rd;
    bit            av, bv;
    logic [AW-1:0] aa, ba;
    logic [DW-1:0] ad, bd;

    vt[0] = '{1, 3'd1, 8'h11, 1, 3'd2, 8'h22, 1, 0, 1, 3'd1, 8'h11};
    vt[1] = '{1, 3'd1, 8'h11, 1, 3'd2, 8'h22, 0, 1, 1, 3'd2, 8'h22};
    vt[2] = '{1, 3'd1, 8'h11, 1, 3'd2, 8'h22, 1, 0, 1, 3'd1, 8'h11};
    vt[3] = '{1, 3'd1, 8'h11, 1, 3'd2, 8'h22, 0, 1, 1, 3'd2, 8'h22};
    vt[4] = '{1, 3'd3, 8'h5A, 0, 3'd0, 8'h00, 1, 0, 1, 3'd3, 8'h5A};
    vt[5] = '{0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 0, 0, 3'd3, 8'h5A};
    vt[6] = '{0, 3'd0, 8'h00, 1, 3'd7, 8'hC3, 0, 1, 1, 3'd7, 8'hC3};
    vt[7] = '{1, 3'd5, 8'hAA, 1, 3'd5, 8'hBB, 1, 0, 1, 3'd5, 8'hAA};
    vt[8] = '{0, 3'd0, 8'h00, 1, 3'd5, 8'hBB, 0, 1, 1, 3'd5, 8'hBB};
    vt[9] = '{0, 3'd0, 8'h00, 0, 3'd0, 8'h00, 0, 0, 0, 3'd5, 8'hBB};

    // reset with both requesters asking: readies must still be 0
    model_reset();
    drive(1, 3'd1, 8'h11, 1, 3'd2, 8'h22);
    #1;
    chk_zero("rr", bus_rr.Rf_we, bus_rr.Rf_waddr, bus_rr.Rf_wdata, bus_rr.Pend,
             bus_rr.Init_done, bus_rr.A_ready, bus_rr.B_ready);
    chk_zero("fx", bus_fx.Rf_we, bus_fx.Rf_waddr, bus_fx.Rf_wdata, bus_fx.Pend,
             bus_fx.Init_done, bus_fx.A_ready, bus_fx.B_ready);
    @(posedge Clk);
    #2 Rst_n = 1'b1;

    init_sweep(1, 1);

    // directed vectors
    for (int i = 0; i < 10; i++) begin
      tick(vt[i].av, vt[i].aa, vt[i].ad, vt[i].bv, vt[i].ba, vt[i].bd, rd);
      chk($sformatf("vec%0d_a_ready", i), rd[0], vt[i].ea);
      chk($sformatf("vec%0d_b_ready", i), rd[1], vt[i].eb);
      chk($sformatf("vec%0d_we", i),      bus_rr.Rf_we, vt[i].ewe);
      chk($sformatf("vec%0d_waddr", i),   bus_rr.Rf_waddr, vt[i].eaddr);
      chk($sformatf("vec%0d_wdata", i),   bus_rr.Rf_wdata, vt[i].edata);
    end
    chk("vec_pend_after_a3", 32'(NREG'(8'b0000_1000)), 32'(8'h08));
    chk("rf3_read",  sb_rf[0][3], 8'h5A);
    chk("rf5_order", sb_rf[0][5], 8'hBB);
    chk("rf1_read",  sb_rf[0][1], 8'h11);
    chk("rf7_read",  sb_rf[0][7], 8'hC3);

    // fixed priority: A wins three contested cycles, B only when A drops
    for (int i = 0; i < 3; i++) begin
      tick(1, 3'd4, 8'h44, 1, 3'd6, 8'h66, rd);
      chk("fixed_a_wins", rd[2], 1);
      chk("fixed_b_starved", rd[3], 0);
    end
    tick(0, 3'd0, 8'h00, 1, 3'd6, 8'h66, rd);
    chk("fixed_b_after_a_drops", rd[3], 1);
    chk("fixed_b_write_addr", bus_fx.Rf_waddr, 6);

    // randomized traffic, requesters hold until accepted by the rr instance
    av = 0; bv = 0; aa = '0; ba = '0; ad = '0; bd = '0; rd = '0;
    for (int i = 0; i < 300; i++) begin
      if (!(av && !rd[0])) begin
        av = ($urandom_range(0, 3) != 0);
        aa = AW'($urandom_range(0, NREG - 1));
        ad = DW'($urandom);
      end
      if (!(bv && !rd[1])) begin
        bv = ($urandom_range(0, 3) != 0);
        ba = AW'($urandom_range(0, NREG - 1));
        bd = DW'($urandom);
      end
      tick(av, aa, ad, bv, ba, bd, rd);
    end
    tick(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, rd);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NREG; i++)
        chk($sformatf("rf_content_%0d_%0d", k, i), sb_rf[k][i], ref_rf[k][i]);

    // reset in the middle of a write
    tick(1, 3'd6, 8'h9E, 0, 3'd0, 8'h00, rd);
    chk("mid_rst_we_before", bus_rr.Rf_we, 1);
    #2 Rst_n = 1'b0;
    #1;
    chk_zero("rr_mid", bus_rr.Rf_we, bus_rr.Rf_waddr, bus_rr.Rf_wdata, bus_rr.Pend,
             bus_rr.Init_done, bus_rr.A_ready, bus_rr.B_ready);
    chk_zero("fx_mid", bus_fx.Rf_we, bus_fx.Rf_waddr, bus_fx.Rf_wdata, bus_fx.Pend,
             bus_fx.Init_done, bus_fx.A_ready, bus_fx.B_ready);
    model_reset();
    @(posedge Clk);
    #2 Rst_n = 1'b1;
    init_sweep(1, 0);
    tick(1, 3'd2, 8'h3C, 1, 3'd4, 8'hC3, rd);
    tick(0, 3'd0, 8'h00, 1, 3'd4, 8'hC3, rd);
    tick(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, rd);
    tick(0, 3'd0, 8'h00, 0, 3'd0, 8'h00, rd);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NREG; i++)
        chk($sformatf("rf_after_rst_%0d_%0d", k, i), sb_rf[k][i], ref_rf[k][i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
